// File: rtl/rho_inv_serial.sv
// rtl/rho_inv_serial.sv - serial inverse Keccak rho, one lane per cycle through a shared rotator
//
// Accepts a 5x5x64 Keccak state and rotates each lane right by its rho offset.
// The state is held in one 1600-bit register. The lanes are rewritten in place,
// in the order k = 0..24, using a single 64-bit rotator.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    input handshake; ready only while idle
//   state_i                    input state, indexed [x][y]
//   out_valid_o / out_ready_i  output handshake; valid only while done
//   state_o                    result, driven straight from the state register
//   busy_o                     high while lanes are being rotated
//   clear_i                    synchronous abort back to idle

package keccak_pkg;
    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;
endpackage

module rho_inv_serial
    import keccak_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_valid_i,
    output logic                                             in_ready_o,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_i,
    output logic                                             out_valid_o,
    input  logic                                             out_ready_i,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_o,
    output logic                                             busy_o,
    input  logic                                             clear_i
);

    localparam int NUM_LANES = ROW_SIZE * COL_SIZE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [4:0] k_q, k_d;

    // The [x][y] packed layout places lane (x,y) at flat index x*5+y.
    // That flat index is exactly the lane counter k, so a flat lane view
    // makes k address the register directly.
    logic [NUM_LANES-1:0][LANE_SIZE-1:0] lanes_q, lanes_d;

    logic [LANE_SIZE-1:0]   cur_lane;
    logic [LANE_SIZE-1:0]   rot_lane;
    logic [2*LANE_SIZE-1:0] dbl_lane;
    logic [5:0]             cur_off;

    function automatic logic [5:0] rho_off(input logic [4:0] idx);
        logic [5:0] r;
        case (idx)
            5'd0:    r = 6'd0;
            5'd1:    r = 6'd36;
            5'd2:    r = 6'd3;
            5'd3:    r = 6'd41;
            5'd4:    r = 6'd18;
            5'd5:    r = 6'd1;
            5'd6:    r = 6'd44;
            5'd7:    r = 6'd10;
            5'd8:    r = 6'd45;
            5'd9:    r = 6'd2;
            5'd10:   r = 6'd62;
            5'd11:   r = 6'd6;
            5'd12:   r = 6'd43;
            5'd13:   r = 6'd15;
            5'd14:   r = 6'd61;
            5'd15:   r = 6'd28;
            5'd16:   r = 6'd55;
            5'd17:   r = 6'd25;
            5'd18:   r = 6'd21;
            5'd19:   r = 6'd56;
            5'd20:   r = 6'd27;
            5'd21:   r = 6'd20;
            5'd22:   r = 6'd39;
            5'd23:   r = 6'd8;
            5'd24:   r = 6'd14;
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Shifting the doubled lane rotates it without any shift-by-64 special
    // case, so an offset of 0 is a clean identity.
    always_comb begin
        cur_lane = lanes_q[k_q];
        cur_off  = rho_off(k_q);
        dbl_lane = {cur_lane, cur_lane} >> cur_off;
        rot_lane = dbl_lane[LANE_SIZE-1:0];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lanes_d = lanes_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    lanes_d = state_i;
                    k_d     = 5'd0;
                    state_d = S_ROTATE;
                end
            end
            S_ROTATE: begin
                lanes_d[k_q] = rot_lane;
                if (k_q == 5'(NUM_LANES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // An abort wins over every transition. The register contents are left
        // as they are because nothing reads them until the next load.
        if (clear_i) begin
            state_d = S_IDLE;
            k_d     = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 5'd0;
            lanes_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lanes_q <= lanes_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_ROTATE);
    assign state_o     = lanes_q;

endmodule
